// File: rtl/cpu4_program_sequencer.sv
// Program sequencer for the 4-bit accumulator CPU: instruction memory, pc, and
// valid/ready/done issue to the datapath. Optional breakpoint: SEQ_BREAKPOINT_EN.
module cpu4_program_sequencer #(
  parameter int PC_W         = 4,
  parameter int DONE_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            halt_req,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [11:0]     prog_data,
  input  logic            pc_load,
  output logic            issue_valid,
  input  logic            issue_ready,
  output logic [3:0]      issue_opcode,
  output logic [3:0]      issue_addr,
  output logic [3:0]      issue_data,
  input  logic            issue_done,
  input  logic            acc_zero,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err_timeout
`ifdef SEQ_BREAKPOINT_EN
  ,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  output logic            bp_hit
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, HALT} state_t;

  state_t          state, state_n;
  logic [11:0]     mem [2**PC_W];
  logic [11:0]     ir;
  logic [PC_W-1:0] pc_n;
  logic            mode_step, mode_step_n;
  logic            halt_latch, halt_latch_n;
  logic            err_n;
  logic [7:0]      cnt, cnt_n;
  logic [3:0]      op_n, addr_n, data_n;
  logic            done_instr, fetch_en, mem_we;
`ifdef SEQ_BREAKPOINT_EN
  logic            first_fetch, first_fetch_n, bp_hit_n;
`endif

  assign issue_valid = (state == ISSUE);
  assign busy        = (state != IDLE) && (state != HALT);
  assign halted      = (state == HALT);

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    mode_step_n  = mode_step;
    halt_latch_n = halt_latch | (halt_req & busy);
    cnt_n        = cnt;
    err_n        = err_timeout;
    op_n         = issue_opcode;
    addr_n       = issue_addr;
    data_n       = issue_data;
    done_instr   = 1'b0;
    fetch_en     = 1'b0;
    mem_we       = 1'b0;
`ifdef SEQ_BREAKPOINT_EN
    first_fetch_n = first_fetch;
    bp_hit_n      = bp_hit;
`endif
    case (state)
      IDLE, HALT: begin
        mem_we = prog_we;
        if (pc_load) pc_n = prog_addr;
        if (start) err_n = 1'b0;
        if (start || step) begin
          state_n     = FETCH;
          mode_step_n = step;
`ifdef SEQ_BREAKPOINT_EN
          first_fetch_n = 1'b1;
          bp_hit_n      = 1'b0;
`endif
        end
      end
      FETCH: begin
`ifdef SEQ_BREAKPOINT_EN
        first_fetch_n = 1'b0;
        // The first fetch after start/step is exempt so a run can resume from the breakpoint
        if (bp_en && (pc == bp_addr) && !first_fetch) begin
          state_n  = HALT;
          bp_hit_n = 1'b1;
        end else
`endif
        begin
          fetch_en = 1'b1;
          state_n  = DECODE;
        end
      end
      DECODE: begin
        case (ir[11:8])
          4'hB, 4'hE: begin
            pc_n       = pc + PC_W'(1);
            done_instr = 1'b1;
          end
          4'hC: begin
            pc_n       = PC_W'(ir[7:4]);
            done_instr = 1'b1;
          end
          4'hD: begin
            pc_n       = acc_zero ? PC_W'(ir[7:4]) : pc + PC_W'(1);
            done_instr = 1'b1;
          end
          4'hF: state_n = HALT;
          default: begin
            op_n    = ir[11:8];
            addr_n  = ir[7:4];
            data_n  = ir[3:0];
            state_n = ISSUE;
          end
        endcase
      end
      ISSUE: begin
        if (issue_ready) begin
          state_n = WAIT;
          cnt_n   = '0;
        end
      end
      WAIT: begin
        if (issue_done) begin
          pc_n       = pc + PC_W'(1);
          done_instr = 1'b1;
        end else if (cnt == 8'(DONE_TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = HALT;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    // A halt_req arriving in the completing cycle itself still counts
    if (done_instr) state_n = (halt_latch_n || mode_step) ? HALT : FETCH;
    if (state_n == HALT) halt_latch_n = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      mode_step    <= 1'b0;
      halt_latch   <= 1'b0;
      cnt          <= '0;
      err_timeout  <= 1'b0;
      issue_opcode <= '0;
      issue_addr   <= '0;
      issue_data   <= '0;
`ifdef SEQ_BREAKPOINT_EN
      first_fetch  <= 1'b0;
      bp_hit       <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      mode_step    <= mode_step_n;
      halt_latch   <= halt_latch_n;
      cnt          <= cnt_n;
      err_timeout  <= err_n;
      issue_opcode <= op_n;
      issue_addr   <= addr_n;
      issue_data   <= data_n;
`ifdef SEQ_BREAKPOINT_EN
      first_fetch  <= first_fetch_n;
      bp_hit       <= bp_hit_n;
`endif
    end
  end

  // Program memory and instruction register are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[prog_addr] <= prog_data;
    if (fetch_en) ir <= mem[pc];
  end

endmodule
